// File: rtl/parallel_to_serial.sv
// Parallel-in, serial-out transmitter with a one-word holding buffer so that
// consecutive words stream out back-to-back on serial_data/serial_valid.
module parallel_to_serial #(
    parameter int DATA_WIDTH = 8,
    parameter int LSB_FIRST  = 1,
    parameter int GAP_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  serial_data,
    output logic                  serial_valid,
    output logic                  frame_start,
    output logic                  word_done,
    output logic                  busy,
    output logic [1:0]            state_dbg
);

    // Handshake: a word transfers at a rising edge where in_valid && in_ready;
    // in_ready is high exactly when the holding buffer is empty.

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam int GAP_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);
    localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t                state;
    state_t                state_next;
    logic [DATA_WIDTH-1:0] hold_reg;
    logic                  hold_valid;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic [DATA_WIDTH-1:0] shift_next;
    logic [CNT_W-1:0]      bit_cnt;
    logic [CNT_W-1:0]      bit_next;
    logic [GAP_W-1:0]      gap_cnt;
    logic [GAP_W-1:0]      gap_next;
    logic                  load;
    logic                  accept;
    logic                  bit_next_val;

    assign in_ready  = ~hold_valid;
    assign accept    = in_valid & ~hold_valid;
    assign busy      = (state != IDLE) | hold_valid;
    assign state_dbg = state;

    always_comb begin
        state_next = state;
        shift_next = shift_reg;
        bit_next   = bit_cnt;
        gap_next   = gap_cnt;
        load       = 1'b0;
        case (state)
            IDLE: begin
                if (hold_valid) begin
                    load = 1'b1;
                end
            end
            SHIFT: begin
                if (bit_cnt == LAST_BIT) begin
                    bit_next = '0;
                    if (GAP_CYCLES > 0) begin
                        state_next = GAP;
                        gap_next   = '0;
                    end else if (hold_valid) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    bit_next = bit_cnt + 1'b1;
                    if (LSB_FIRST != 0) begin
                        shift_next = {1'b0, shift_reg[DATA_WIDTH-1:1]};
                    end else begin
                        shift_next = {shift_reg[DATA_WIDTH-2:0], 1'b0};
                    end
                end
            end
            GAP: begin
                if (gap_cnt == LAST_GAP) begin
                    gap_next = '0;
                    if (hold_valid) begin
                        load = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    gap_next = gap_cnt + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
        if (load) begin
            state_next = SHIFT;
            shift_next = hold_reg;
            bit_next   = '0;
        end
    end

    // The bit at the output end of shift_next is the one shown next cycle.
    always_comb begin
        bit_next_val = 1'b0;
        if (LSB_FIRST != 0) begin
            bit_next_val = shift_next[0];
        end else begin
            bit_next_val = shift_next[DATA_WIDTH-1];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
        end else begin
            state     <= state_next;
            shift_reg <= shift_next;
            bit_cnt   <= bit_next;
            gap_cnt   <= gap_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hold_reg   <= '0;
            hold_valid <= 1'b0;
        end else if (accept) begin
            hold_reg   <= in_data;
            hold_valid <= 1'b1;
        end else if (load) begin
            hold_valid <= 1'b0;
        end
    end

    // Registered line outputs, computed from the state being entered.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            serial_data  <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            word_done    <= 1'b0;
        end else begin
            serial_data  <= (state_next == SHIFT) & bit_next_val;
            serial_valid <= (state_next == SHIFT);
            frame_start  <= (state_next == SHIFT) & (bit_next == '0);
            word_done    <= (state_next == SHIFT) & (bit_next == LAST_BIT);
        end
    end

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: three configurations (LSB/GAP0, MSB/GAP0,
// LSB/GAP3) checked against a word-queue model of the serial stream.
module tb_parallel_to_serial;

    logic       clk;
    logic       reset;
    logic [7:0] in_data   [3];
    logic       in_valid  [3];
    logic       in_ready  [3];
    logic       sd        [3];
    logic       sv        [3];
    logic       fs        [3];
    logic       wd        [3];
    logic       busy      [3];
    logic [1:0] st        [3];

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_q [3][$];
    int         pos    [3];
    int         fs_cnt [3];
    int         wd_cnt [3];

    parallel_to_serial #(.DATA_WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(0)) u_dut0 (
        .clk(clk), .reset(reset), .in_data(in_data[0]), .in_valid(in_valid[0]),
        .in_ready(in_ready[0]), .serial_data(sd[0]), .serial_valid(sv[0]),
        .frame_start(fs[0]), .word_done(wd[0]), .busy(busy[0]), .state_dbg(st[0]));

    parallel_to_serial #(.DATA_WIDTH(8), .LSB_FIRST(0), .GAP_CYCLES(0)) u_dut1 (
        .clk(clk), .reset(reset), .in_data(in_data[1]), .in_valid(in_valid[1]),
        .in_ready(in_ready[1]), .serial_data(sd[1]), .serial_valid(sv[1]),
        .frame_start(fs[1]), .word_done(wd[1]), .busy(busy[1]), .state_dbg(st[1]));

    parallel_to_serial #(.DATA_WIDTH(8), .LSB_FIRST(1), .GAP_CYCLES(3)) u_dut2 (
        .clk(clk), .reset(reset), .in_data(in_data[2]), .in_valid(in_valid[2]),
        .in_ready(in_ready[2]), .serial_data(sd[2]), .serial_valid(sv[2]),
        .frame_start(fs[2]), .word_done(wd[2]), .busy(busy[2]), .state_dbg(st[2]));

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int lsb_of(input int i);
        return (i == 1) ? 0 : 1;
    endfunction

    // driver tasks
    task automatic send(input int i, input logic [7:0] w);
        bit done = 0;
        for (int k = 0; k < 200 && !done; k++) begin
            @(negedge clk);
            in_valid[i] = 1'b1;
            if (in_ready[i]) begin
                in_data[i] = w;
                @(posedge clk);
                #1;
                exp_q[i].push_back(w);
                check("rdy_after_accept", in_ready[i], 0);
                done = 1;
            end else begin
                in_data[i] = 8'($urandom_range(0, 255));
            end
        end
        if (!done) check("send_timeout", in_ready[i], 1);
    endtask

    task automatic idle(input int i);
        in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            #1;
            if (exp_q[i].size() == 0 && !busy[i]) break;
        end
        check("drain_queue", exp_q[i].size(), 0);
        check("drain_busy", busy[i], 0);
        check("drain_ready", in_ready[i], 1);
    endtask

    task automatic lat_test(input int i, input logic [7:0] w);
        logic [0:7] seq;
        seq = (lsb_of(i) != 0) ? 8'b00101101 : 8'b10110100;
        send(i, w);
        idle(i);
        for (int k = 0; k <= 10; k++) begin
            @(negedge clk);
            check("lat_valid", sv[i], (k >= 1 && k <= 8));
            check("lat_fs", fs[i], (k == 1));
            check("lat_wd", wd[i], (k == 8));
            check("lat_busy", busy[i], (k <= 8));
            if (k >= 1 && k <= 8 && w == 8'hB4) check("lat_bit", sd[i], seq[k-1]);
        end
    endtask

    // scoreboard: expected stream comes from the queue of accepted words
    always @(negedge clk) begin : monitor
        logic [7:0] w;
        int idx;
        for (int i = 0; i < 3; i++) begin
            if (reset) begin
                exp_q[i].delete();
                pos[i] = 0;
            end
            if (fs[i]) fs_cnt[i]++;
            if (wd[i]) wd_cnt[i]++;
            if (sv[i]) begin
                if (exp_q[i].size() == 0) begin
                    check("spurious_valid", sv[i], 0);
                end else begin
                    w = exp_q[i][0];
                    idx = (lsb_of(i) != 0) ? pos[i] : 7 - pos[i];
                    check("serial_bit", sd[i], w[idx]);
                    check("frame_start", fs[i], (pos[i] == 0));
                    check("word_done", wd[i], (pos[i] == 7));
                    if (pos[i] == 7) begin
                        void'(exp_q[i].pop_front());
                        pos[i] = 0;
                    end else begin
                        pos[i]++;
                    end
                end
            end else begin
                check("idle_data", sd[i], 0);
                check("idle_fs", fs[i], 0);
                check("idle_wd", wd[i], 0);
                check("mid_word_gap", pos[i], 0);
            end
        end
    end

    initial begin
        int run;
        int fs0;
        int wd0;
        for (int i = 0; i < 3; i++) begin
            in_valid[i] = 1'b0;
            in_data[i]  = 8'h00;
            pos[i]      = 0;
            fs_cnt[i]   = 0;
            wd_cnt[i]   = 0;
        end
        reset = 1'b1;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("rst_ready", in_ready[i], 1);
            check("rst_valid", sv[i], 0);
            check("rst_busy", busy[i], 0);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            check("post_rst_ready", in_ready[i], 1);
            check("post_rst_busy", busy[i], 0);
        end

        // single word from idle, both bit orders
        lat_test(0, 8'hB4);
        lat_test(1, 8'hB4);

        // three-word stream with in_valid held
        fs0 = fs_cnt[0];
        wd0 = wd_cnt[0];
        run = 0;
        fork
            begin
                send(0, 8'h01);
                send(0, 8'hFF);
                send(0, 8'h80);
                idle(0);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk);
                    if (sv[0]) break;
                end
                if (sv[0]) begin
                    run = 1;
                    for (int k = 0; k < 100; k++) begin
                        @(negedge clk);
                        if (!sv[0]) break;
                        run++;
                    end
                end
            end
        join
        drain(0);
        check("stream_run", run, 24);
        check("stream_fs", fs_cnt[0] - fs0, 3);
        check("stream_wd", wd_cnt[0] - wd0, 3);

        // gap configuration: trace of valid and busy across two words
        fork
            begin
                send(2, 8'hB4);
                send(2, 8'h5A);
                idle(2);
            end
            begin
                for (int k = 0; k < 60; k++) begin
                    @(negedge clk);
                    if (sv[2]) break;
                end
                check("gap_start", sv[2], 1);
                for (int t = 0; t < 30; t++) begin
                    if (t > 0) @(negedge clk);
                    check("gap_valid", sv[2], (t < 8) || (t >= 11 && t < 19));
                    check("gap_busy", busy[2], (t < 22));
                end
            end
        join
        drain(2);

        // asynchronous reset at bit 4 with a second word buffered
        send(0, 8'hB4);
        send(0, 8'h77);
        idle(0);
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            #1;
            if (sv[0] && pos[0] == 5) break;
        end
        check("pre_rst_pos", pos[0], 5);
        check("pre_rst_full", in_ready[0], 0);
        #1;
        reset = 1'b1;
        #1;
        check("arst_valid", sv[0], 0);
        check("arst_data", sd[0], 0);
        check("arst_fs", fs[0], 0);
        check("arst_wd", wd[0], 0);
        check("arst_busy", busy[0], 0);
        check("arst_ready", in_ready[0], 1);
        repeat (2) @(negedge clk);
        #1;
        reset = 1'b0;
        repeat (20) @(negedge clk);
        #1;
        check("post_arst_ready", in_ready[0], 1);
        check("post_arst_busy", busy[0], 0);
        lat_test(0, 8'h3C);

        // randomized streams with random idle spacing
        for (int i = 0; i < 3; i++) begin
            fs0 = fs_cnt[i];
            for (int n = 0; n < 20; n++) begin
                send(i, 8'($urandom_range(0, 255)));
                if ($urandom_range(0, 3) == 0) begin
                    idle(i);
                    repeat ($urandom_range(1, 12)) @(negedge clk);
                end
            end
            idle(i);
            drain(i);
            check("rand_frames", fs_cnt[i] - fs0, 20);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        check("global_timeout", 1, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Parallel-in, serial-out transmitter that takes words over a valid/ready handshake and shifts them out one bit per clock on a single serial line with a qualifying valid strobe. It sits directly upstream of the serial-to-parallel receiver and drives that block's serial data input. A one-word holding buffer allows the next word to be accepted while the current word is shifting, so streaming runs back-to-back with no idle cycles.

## Interface
- DATA_WIDTH, 8, word width in bits; legal range ≥ 2.
- LSB_FIRST, 1, 1 = transmit in_data[0] first; 0 = transmit in_data[DATA_WIDTH-1] first.
- GAP_CYCLES, 0, number of idle cycles inserted after every word; legal range 0..255.
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  DATA_WIDTH  word to transmit.
- in_valid  input  1  in_data is valid this cycle.
- in_ready  output  1  holding buffer is empty; defined as ~hold_valid (combinational).
- serial_data  output  1  serial bit; forced to 0 whenever serial_valid = 0.
- serial_valid  output  1  serial_data carries a data bit this cycle.
- frame_start  output  1  one-cycle pulse concurrent with the first bit of each word.
- word_done  output  1  one-cycle pulse concurrent with the last bit of each word.
- busy  output  1  state != IDLE or hold_valid.

## Operation
- Storage:
  - hold_reg/hold_valid form a one-entry buffer.
  - shift_reg holds the word currently being transmitted.
  - bit_cnt counts 0..DATA_WIDTH-1.
  - gap_cnt counts 0..GAP_CYCLES-1.
- Accept: a word is taken when in_valid && in_ready at a rising edge. in_data is written to hold_reg and hold_valid is set.
- FSM states are IDLE, SHIFT and GAP.
  - IDLE: if hold_valid, load shift_reg ← hold_reg, clear hold_valid, clear bit_cnt, go to SHIFT.
  - SHIFT:
    - Each cycle, drive the current bit and set serial_valid = 1.
    - LSB_FIRST=1: drive shift_reg[0], shift right. LSB_FIRST=0: drive shift_reg[DATA_WIDTH-1], shift left.
    - Increment bit_cnt every cycle.
    - On the last bit (bit_cnt == DATA_WIDTH-1):
      - If GAP_CYCLES > 0: go to GAP.
      - Else if hold_valid: reload shift_reg from hold_reg, clear hold_valid, reset bit_cnt, stay in SHIFT.
      - Else: go to IDLE.
  - GAP: hold serial_valid = 0 for GAP_CYCLES cycles. Then load from the buffer and go to SHIFT if hold_valid; otherwise go to IDLE.
- Outputs:
  - serial_data, serial_valid, frame_start and word_done are registered (driven from state and shift_reg, not from in_data).
  - frame_start = serial_valid && bit_cnt == 0.
  - word_done = serial_valid && bit_cnt == DATA_WIDTH-1.
- Simultaneous events:
  - At an edge where the buffer transfers to shift_reg, in_ready is 0, so no accept occurs. The accept happens at the next edge, once in_ready has risen.
  - in_valid held with in_ready = 0 is a stall. The word stays pending and is never dropped or duplicated.
  - in_data may change while in_ready = 0. Only the value present at the accepting edge is used.
- Widths:
  - bit_cnt is $clog2(DATA_WIDTH) bits.
  - gap_cnt is max(1, $clog2(GAP_CYCLES+1)) bits.
  - No counter ever reaches a value it cannot represent.

## Timing
- Reset values:
  - state = IDLE, hold_valid = 0, shift_reg = 0, bit_cnt = 0, gap_cnt = 0.
  - serial_data = 0, serial_valid = 0, frame_start = 0, word_done = 0, busy = 0.
  - in_ready = 1, both during and after reset.
- Reset mid-word: all outputs clear asynchronously. The partial word and any buffered word are discarded, and no further bits of either are emitted after release.
- Latency, idle block: word accepted at edge N; first bit (frame_start=1) is visible after edge N+1; last bit (word_done=1) is visible after edge N+DATA_WIDTH.
- Throughput with GAP_CYCLES=0: one word per DATA_WIDTH cycles with serial_valid continuously high, provided each next word is accepted before the current last bit.
- With GAP_CYCLES=G: exactly G cycles of serial_valid=0 follow every word, including the final one.
- in_ready rises the cycle after the buffer transfers into shift_reg.

## Test plan
- Reset, then send 8'hB4 with LSB_FIRST=1, GAP=0 → serial bits 0,0,1,0,1,1,0,1 over 8 consecutive cycles; frame_start on bit 0, word_done on bit 7, then serial_valid=0, busy=0.
- Same word with LSB_FIRST=0 → bits 1,0,1,1,0,1,0,0.
- Stream 8'h01, 8'hFF, 8'h80 with in_valid held high → 24 contiguous serial_valid cycles, no gaps; in_ready drops while the buffer is full; exactly three frame_start and three word_done pulses.
- GAP_CYCLES=3, two words back-to-back → exactly 3 cycles of serial_valid=0 between the words and 3 after the last; serial_data=0 during the gaps.
- Hold in_valid high with in_ready=0 and change in_data each cycle → only the value present at the accepting edge is transmitted.
- Assert reset asynchronously at bit 4 of 8'hB4 with a second word buffered → outputs drop immediately; after release no bits are emitted until a new word is accepted, and in_ready = 1.
